// File: rtl/rgb_pix_asm.sv
// WS2812b pixel assembler: turns per-bit strobes into GRB words on a one-entry valid/ready register.
// Optional RGB_PIX_ASM_RGBW_EN extracts a white channel (min of G,R,B) at load time.
module rgb_pix_asm #(
  parameter int BITS_PER_PIXEL = 24,
  parameter int PIX_IDX_WIDTH  = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bit_in,
  input  logic                      bit_strobe,
  input  logic                      bit_stream_reset,
  output logic [BITS_PER_PIXEL-1:0] pix_data,
  output logic [7:0]                pix_w,
  output logic [PIX_IDX_WIDTH-1:0]  pix_idx,
  output logic                      pix_first,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic                      overflow,
  output logic                      frame_err,
  input  logic                      err_clr
);

  localparam logic [0:0] ST_SYNC = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam int CNT_W = $clog2(BITS_PER_PIXEL);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS_PER_PIXEL - 1);
  localparam logic [PIX_IDX_WIDTH-1:0] IDX_MAX = '1;

  logic [0:0]                state_q, state_d;
  logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic [BITS_PER_PIXEL-2:0] shift_q, shift_d;
  logic [PIX_IDX_WIDTH-1:0]  frame_idx_q, frame_idx_d;
  logic                      first_q, first_d;
  logic [BITS_PER_PIXEL-1:0] pix_data_q, pix_data_d;
  logic [7:0]                pix_w_q, pix_w_d;
  logic [PIX_IDX_WIDTH-1:0]  pix_idx_q, pix_idx_d;
  logic                      pix_first_q, pix_first_d;
  logic                      pix_valid_q, pix_valid_d;
  logic                      overflow_q, overflow_d;
  logic                      frame_err_q, frame_err_d;

  logic                      bit_ev, srst_ev, word_ev, load_ev, drop_ev, ferr_set;
  logic [BITS_PER_PIXEL-1:0] word_data, load_data;
  logic [7:0]                load_w;

  always_comb begin
    bit_ev    = bit_strobe && !bit_stream_reset;
    srst_ev   = bit_strobe && bit_stream_reset;
    word_ev   = (state_q == ST_RUN) && bit_ev && (bit_cnt_q == LAST_BIT);
    word_data = {shift_q, bit_in};
    load_ev   = word_ev && (!pix_valid_q || pix_ready);
    drop_ev   = word_ev && pix_valid_q && !pix_ready;
  end

`ifdef RGB_PIX_ASM_RGBW_EN
  // White is the common floor of G, R and B; only the low 24 bits take part.
  logic [7:0] g_c, r_c, b_c, min_gr;
  always_comb begin
    g_c       = word_data[23:16];
    r_c       = word_data[15:8];
    b_c       = word_data[7:0];
    min_gr    = (g_c < r_c) ? g_c : r_c;
    load_w    = (min_gr < b_c) ? min_gr : b_c;
    load_data = word_data;
    load_data[23:0] = {g_c - load_w, r_c - load_w, b_c - load_w};
  end
`else
  always_comb begin
    load_w    = 8'd0;
    load_data = word_data;
  end
`endif

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_idx_d = frame_idx_q;
    first_d     = first_q;
    ferr_set    = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (srst_ev) begin
          state_d     = ST_RUN;
          bit_cnt_d   = '0;
          shift_d     = '0;
          frame_idx_d = '0;
          first_d     = 1'b1;
        end
      end
      default: begin
        if (srst_ev) begin
          ferr_set    = (bit_cnt_q != '0);
          bit_cnt_d   = '0;
          shift_d     = '0;
          frame_idx_d = '0;
          first_d     = 1'b1;
        end else if (bit_ev) begin
          shift_d   = word_data[BITS_PER_PIXEL-2:0];
          bit_cnt_d = word_ev ? '0 : bit_cnt_q + 1'b1;
          if (word_ev) begin
            // Index advances for dropped words too so the consumer can see the gap.
            frame_idx_d = (frame_idx_q == IDX_MAX) ? frame_idx_q : frame_idx_q + 1'b1;
            first_d     = 1'b0;
          end
        end
      end
    endcase
  end

  always_comb begin
    pix_data_d  = pix_data_q;
    pix_w_d     = pix_w_q;
    pix_idx_d   = pix_idx_q;
    pix_first_d = pix_first_q;
    pix_valid_d = pix_valid_q;
    if (load_ev) begin
      pix_data_d  = load_data;
      pix_w_d     = load_w;
      pix_idx_d   = frame_idx_q;
      pix_first_d = first_q;
      pix_valid_d = 1'b1;
    end else if (pix_valid_q && pix_ready) begin
      pix_valid_d = 1'b0;
    end
    overflow_d  = (overflow_q && !err_clr) || drop_ev;
    frame_err_d = (frame_err_q && !err_clr) || ferr_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SYNC;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_idx_q <= '0;
      first_q     <= 1'b0;
      pix_data_q  <= '0;
      pix_w_q     <= '0;
      pix_idx_q   <= '0;
      pix_first_q <= 1'b0;
      pix_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_idx_q <= frame_idx_d;
      first_q     <= first_d;
      pix_data_q  <= pix_data_d;
      pix_w_q     <= pix_w_d;
      pix_idx_q   <= pix_idx_d;
      pix_first_q <= pix_first_d;
      pix_valid_q <= pix_valid_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign pix_data  = pix_data_q;
  assign pix_w     = pix_w_q;
  assign pix_idx   = pix_idx_q;
  assign pix_first = pix_first_q;
  assign pix_valid = pix_valid_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/rgb_pix_asm.md
Name: rgb_pix_asm

Overview:
- Downstream neighbour of the WS2812b serial-bit capture stage in the 96 MHz domain.
- Consumes that stage's per-bit strobes (`out`, `strobe`, `stream_reset`) and assembles 24-bit GRB pixel words, MSB first.
- Tracks pixel index within a frame and presents each word on a one-entry valid/ready output register to the RGBW conversion/output stage.
- Flags dropped words and truncated frames.

Parameters:
- BITS_PER_PIXEL, 24, bits per assembled word; must be a multiple of 8 and ≥ 24.
- PIX_IDX_WIDTH, 10, width of the pixel index counter; saturates at 2^PIX_IDX_WIDTH-1.

Ports:
- clk  input  1  system clock, 96 MHz.
- rst  input  1  synchronous, active-high reset.
- bit_in  input  1  bit value from capture stage; meaningful only when bit_strobe=1 and bit_stream_reset=0.
- bit_strobe  input  1  one-cycle qualifier for bit_in or bit_stream_reset.
- bit_stream_reset  input  1  with bit_strobe: 50 µs stream reset (frame boundary).
- pix_data  output  BITS_PER_PIXEL  assembled word; first-received bit at MSB. For 24: G[23:16], R[15:8], B[7:0].
- pix_w  output  8  white channel; 0 unless RGB_PIX_ASM_RGBW_EN.
- pix_idx  output  PIX_IDX_WIDTH  index of pix_data within the current frame.
- pix_first  output  1  pix_data is the first word after a stream reset.
- pix_valid  output  1  output register holds an unconsumed word.
- pix_ready  input  1  consumer accepts; transfer occurs when pix_valid && pix_ready at posedge clk.
- overflow  output  1  sticky: a completed word was dropped.
- frame_err  output  1  sticky: stream reset arrived mid-word.
- err_clr  input  1  clears overflow and frame_err.

Behaviour:
- Reset, synchronous and active-high. Values:
  - pix_data, pix_w, pix_idx = 0.
  - pix_first, pix_valid, overflow, frame_err = 0.
  - Bit counter and shift register = 0.
  - FSM enters SYNC.
  - Reset mid-word or mid-transfer discards everything.
- Event definitions:
  - BIT = bit_strobe && !bit_stream_reset.
  - SRST = bit_strobe && bit_stream_reset.
- FSM SYNC: ignore BIT.
  - SRST -> RUN, bit counter = 0, frame index = 0, first-flag = 1.
  - Discards bits from power-up mid-stream.
- FSM RUN, on BIT:
  - shift = {shift[N-2:0], bit_in}.
  - Bit counter increments; when it reaches BITS_PER_PIXEL-1, the word completes (WORD) and the counter wraps to 0.
- FSM RUN, on SRST:
  - If bit counter != 0: set frame_err, discard partial word.
  - Bit counter = 0, frame index = 0, first-flag = 1.
  - Stay in RUN.
  - A held output word is unaffected.
- Word timing: pix_valid rises on the clock edge after the strobe cycle carrying the last bit (latency 1 clk). Loaded together with pix_valid:
  - pix_data = completed shift value.
  - pix_idx = frame index.
  - pix_first = first-flag.
- After a load: frame index increments (saturating), first-flag clears.
- Output handshake:
  - pix_valid && pix_ready, no WORD: pix_valid -> 0 next edge.
  - WORD && (!pix_valid || pix_ready): load new word, pix_valid = 1. Covers back-to-back accept and load in the same cycle.
  - WORD && pix_valid && !pix_ready: new word dropped, overflow set, frame index still increments; held word and its outputs stay stable.
- Output stability: pix_data, pix_w, pix_idx and pix_first change only on a load; they hold while pix_valid && !pix_ready.
- Sticky flags:
  - err_clr clears overflow and frame_err.
  - If err_clr coincides with a new setting event, the set wins.
- Simultaneous bit_strobe and bit_stream_reset is treated as SRST only.
- bit_in is ignored when bit_strobe=0.

Optional Feature:
- RGB_PIX_ASM_RGBW_EN defined:
  - At load, for the low 24 bits: W = min(G,R,B); pix_w = W; each of G, R, B is replaced by itself minus W. Bits above 24 pass unchanged.
  - Combinational before the output register; latency remains 1 clk.
- Not defined: pix_w tied to 0; pix_data is the raw assembled word.

Test Plan:
- Reset, then 24 BIT strobes of 0xFF0000 with no prior SRST -> pix_valid stays 0 (SYNC discards). Then SRST and 24 bits 0x12AB34 -> pix_valid=1 one clk after the 24th strobe, pix_data=0x12AB34, pix_idx=0, pix_first=1.
- With pix_ready=1, three words 0x010203, 0x040506, 0x070809 -> pix_idx 0,1,2; pix_first only on the first; each valid pulse lasts 1 clk.
- pix_ready=0, two words 0xAAAAAA then 0x555555 -> pix_data holds 0xAAAAAA, overflow=1. Then pix_ready=1 -> accepted; the next word has pix_idx=2. Then err_clr -> overflow=0.
- SRST after 10 bits -> frame_err=1, no word emitted. The next 24 bits (0x00FF00) emit pix_idx=0, pix_first=1.
- WORD on the same cycle as an accept of the held word -> new word loaded, pix_valid stays 1, no overflow.
- RGBW_EN: input 0x80C040 -> pix_w=0x40, pix_data=0x408000. Without the macro: pix_w=0, pix_data=0x80C040.
